// File: rtl/reloj_pkg.sv
// Shared definitions for the clock's BCD <-> ASCII paths: character constants,
// digit field offsets inside the 24-bit HHMMSS word and the serializer states.
package reloj_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int SEG_U_OFS = 0;
    localparam int SEG_D_OFS = 4;
    localparam int MIN_U_OFS = 8;
    localparam int MIN_D_OFS = 12;
    localparam int HOR_U_OFS = 16;
    localparam int HOR_D_OFS = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_FIN
    } estado_t;

endpackage

// File: rtl/bcd_digit2ascii.sv
// One BCD digit to its ASCII character; non-decimal codes become '?' and
// raise invalid.
module bcd_digit2ascii
    import reloj_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii,
    output logic       invalid
);

    assign invalid = (digit > 4'd9);
    assign ascii   = invalid ? ASCII_QMARK : (ASCII_ZERO + {4'h0, digit});

endmodule

// File: rtl/bcd2ascii_reloj.sv
// Serializes a snapshot of the BCD time as "HH:MM:SS" (optionally CR LF),
// one byte per valid/ready handshake.
module bcd2ascii_reloj
    import reloj_pkg::*;
#(
    parameter logic [7:0] SEP      = ASCII_COLON,
    parameter bit         ADD_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [23:0] BCD,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [3:0] LAST = ADD_CRLF ? 4'd9 : 4'd7;

    estado_t     state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic [23:0] snap_reg;
    logic [7:0]  tx_data_reg;
    logic        err_reg;
    logic        load;
    logic [5:0]  dig_bad;
    logic [23:0] sel_word;
    logic [3:0]  digit_sel;
    logic [7:0]  digit_ascii;
    logic        digit_invalid;
    logic [7:0]  byte_next;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_chk
            assign dig_bad[gi] = (BCD[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (inicio) begin
                    load       = 1'b1;
                    idx_next   = 4'd0;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (idx_reg == LAST) state_next = ST_FIN;
                    else                 idx_next   = idx_reg + 4'd1;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The outgoing byte is computed one cycle early from the next index, so
    // on a start it must come from the live BCD input rather than the snapshot.
    always_comb begin
        sel_word  = load ? BCD : snap_reg;
        digit_sel = 4'h0;
        case (idx_next)
            4'd0: digit_sel = sel_word[HOR_D_OFS +: 4];
            4'd1: digit_sel = sel_word[HOR_U_OFS +: 4];
            4'd3: digit_sel = sel_word[MIN_D_OFS +: 4];
            4'd4: digit_sel = sel_word[MIN_U_OFS +: 4];
            4'd6: digit_sel = sel_word[SEG_D_OFS +: 4];
            4'd7: digit_sel = sel_word[SEG_U_OFS +: 4];
            default: digit_sel = 4'h0;
        endcase
    end

    bcd_digit2ascii u_digit (
        .digit   (digit_sel),
        .ascii   (digit_ascii),
        .invalid (digit_invalid)
    );

    always_comb begin
        byte_next = digit_invalid ? ASCII_QMARK : digit_ascii;
        case (idx_next)
            4'd2, 4'd5: byte_next = SEP;
            4'd8:       byte_next = ASCII_CR;
            4'd9:       byte_next = ASCII_LF;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 4'd0;
            snap_reg    <= 24'h0;
            tx_data_reg <= 8'h00;
            err_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (load) begin
                snap_reg <= BCD;
                err_reg  <= |dig_bad;
            end
            if (state_next == ST_SEND)
                tx_data_reg <= byte_next;
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = (state_reg == ST_SEND);
    assign busy     = (state_reg == ST_SEND);
    assign done     = (state_reg == ST_FIN);
    assign err      = err_reg;

endmodule

// File: tb/tb_bcd2ascii_reloj.sv
// Randomized bench for bcd2ascii_reloj: streams are compared with a character
// model of the HH:MM:SS[CR LF] text built directly from the time digits.
module tb_bcd2ascii_reloj;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inicio, tx_ready;
    logic [23:0] BCD;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done, err;

    logic        inicio8, tx_ready8;
    logic [23:0] bcd8;
    logic [7:0]  tx_data8;
    logic        tx_valid8, busy8, done8, err8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd2ascii_reloj u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio),
        .BCD      (BCD),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    bcd2ascii_reloj #(.SEP(8'h2E), .ADD_CRLF(1'b0)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio8),
        .BCD      (bcd8),
        .tx_data  (tx_data8),
        .tx_valid (tx_valid8),
        .tx_ready (tx_ready8),
        .busy     (busy8),
        .done     (done8),
        .err      (err8)
    );

    // Character at position pos of the text "HH<sep>MM<sep>SS\r\n".
    function automatic logic [7:0] model_byte(logic [23:0] bcd, int pos, logic [7:0] sep);
        int k, d;
        if (pos == 8) return 8'h0D;
        if (pos == 9) return 8'h0A;
        if (pos == 2 || pos == 5) return sep;
        k = 5 - (pos - pos / 3);
        d = int'((bcd >> (4 * k)) % 16);
        if (d < 10) return 8'(48 + d);
        return 8'h3F;
    endfunction

    function automatic bit model_err(logic [23:0] bcd);
        for (int k = 0; k < 6; k++)
            if (((bcd >> (4 * k)) % 16) > 9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; inicio = 1'b0; tx_ready = 1'b0; BCD = 24'h0;
        inicio8 = 1'b0; tx_ready8 = 1'b0; bcd8 = 24'h0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: valid=%b busy=%b done=%b err=%b data=%h, want 0 0 0 0 00",
                     tx_valid, busy, done, err, tx_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b busy=%b done=%b valid8=%b, want all 0",
                     tx_valid, busy, done, tx_valid8);
        end
        $display("reset done");
    endtask

    // One full transaction on the CRLF instance; disturb re-pulses inicio and
    // changes BCD mid-stream and again during the done cycle.
    task automatic test_stream(input logic [23:0] bcd, input int stall_pct, input bit disturb);
        logic [7:0] exp;
        bit         exp_err, rdy;
        int         i, cyc, stalls;
        @(negedge clk);
        BCD = bcd; inicio = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        inicio = 1'b0;
        BCD = 24'($urandom);
        exp_err = model_err(bcd);
        i = 0; cyc = 0; stalls = 0;
        while (i < 10 && cyc < 400) begin
            exp = model_byte(bcd, i, 8'h3A);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp || busy !== 1'b1 || done !== 1'b0 || err !== exp_err) begin
                errors++;
                $display("FAIL stream bcd=%h byte%0d: valid=%b data=%h busy=%b done=%b err=%b, want 1 %h 1 0 %b",
                         bcd, i, tx_valid, tx_data, busy, done, err, exp, exp_err);
            end
            if (disturb && i == 3) begin
                inicio = 1'b1;
                BCD = 24'($urandom);
            end else begin
                inicio = 1'b0;
            end
            rdy = ($urandom_range(99) >= 32'(stall_pct));
            tx_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) i++; else stalls++;
        end
        inicio = disturb;
        tx_ready = 1'($urandom_range(1));
        checks++;
        if (done !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0 || err !== exp_err || cyc != 10 + stalls) begin
            errors++;
            $display("FAIL stream_done bcd=%h: done=%b valid=%b busy=%b err=%b cycles=%0d, want 1 0 0 %b %0d",
                     bcd, done, tx_valid, busy, err, cyc, exp_err, 10 + stalls);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || err !== exp_err) begin
            errors++;
            $display("FAIL stream_idle bcd=%h: done=%b valid=%b busy=%b err=%b, want 0 0 0 %b",
                     bcd, done, tx_valid, busy, err, exp_err);
        end
        inicio = 1'b0; tx_ready = 1'b0;
        $display("stream bcd=%h stalls=%0d cycles=%0d disturb=%0d", bcd, stalls, cyc, disturb);
    endtask

    task automatic test_basic();
        test_stream(24'h235959, 0, 1'b0);
    endtask

    task automatic test_stalls();
        test_stream(24'h120000, 50, 1'b0);
    endtask

    task automatic test_invalid();
        test_stream(24'h1A0F00, 30, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, want 1", err);
        end
        test_stream(24'h000000, 0, 1'b0);
    endtask

    task automatic test_ignore_restart();
        test_stream(24'h074512, 25, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        BCD = 24'h235959; inicio = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== model_byte(24'h235959, 4, 8'h3A)) begin
            errors++;
            $display("FAIL reset_mid_pre: valid=%b data=%h, want 1 %h",
                     tx_valid, tx_data, model_byte(24'h235959, 4, 8'h3A));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b busy=%b done=%b data=%h, want 0 0 0 00",
                     tx_valid, busy, done, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: valid=%b done=%b busy=%b, want 0 0 0", tx_valid, done, busy);
        end
        $display("reset mid-stream after 4 bytes");
        test_stream(24'h235959, 0, 1'b0);
    endtask

    task automatic test_nocrlf();
        logic [23:0] b = 24'h081530;
        logic [7:0]  exp;
        @(negedge clk);
        bcd8 = b; inicio8 = 1'b1; tx_ready8 = 1'b1;
        @(negedge clk);
        inicio8 = 1'b0;
        bcd8 = 24'h999999;
        for (int i = 0; i < 8; i++) begin
            exp = model_byte(b, i, 8'h2E);
            checks++;
            if (tx_valid8 !== 1'b1 || tx_data8 !== exp || done8 !== 1'b0) begin
                errors++;
                $display("FAIL nocrlf byte%0d: valid=%b data=%h done=%b, want 1 %h 0",
                         i, tx_valid8, tx_data8, done8, exp);
            end
            @(negedge clk);
        end
        checks++;
        if (done8 !== 1'b1 || tx_valid8 !== 1'b0 || busy8 !== 1'b0 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL nocrlf_done: done=%b valid=%b busy=%b err=%b, want 1 0 0 0",
                     done8, tx_valid8, busy8, err8);
        end
        @(negedge clk);
        tx_ready8 = 1'b0;
        checks++;
        if (done8 !== 1'b0 || tx_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL nocrlf_idle: done=%b valid=%b, want 0 0", done8, tx_valid8);
        end
        $display("stream8 bcd=%h sep=2E", b);
    endtask

    task automatic test_random();
        logic [23:0] b;
        int h, m, s;
        for (int r = 0; r < 8; r++) begin
            if (r % 3 == 2) begin
                b = 24'($urandom);
            end else begin
                h = int'($urandom_range(23));
                m = int'($urandom_range(59));
                s = int'($urandom_range(59));
                b = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
            end
            test_stream(b, int'($urandom_range(60)), 1'(r % 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_invalid();
        test_ignore_restart();
        test_reset_mid();
        test_nocrlf();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
